// File: rtl/word_counter.sv
// Word counter for a transfer engine: counts down, up-to-compare or with carry-out, per the mode field.
// Optional macro WORD_COUNTER_IRQ_EN enables a one-cycle irq pulse on entry to DONE.
module word_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wc_init,
    input  logic [1:0]       mode,
    input  logic             wcld,
    input  logic             wcen,
    input  logic             clr,
    output logic [WIDTH-1:0] wc,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_DOWN  = 2'b00;
    localparam logic [1:0] M_UP    = 2'b01;
    localparam logic [1:0] M_CARRY = 2'b11;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] wc_q, wc_d;
    logic [WIDTH-1:0] wc_inc, wc_dec;

    assign wc_inc = wc_q + ONE;
    assign wc_dec = wc_q - ONE;

    // Priority is clr > wcld > wcen; a zero load finishes immediately except in carry-out mode.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        if (clr) begin
            state_d = S_IDLE;
            wc_d    = '0;
        end else if (wcld) begin
            wc_d    = (mode == M_UP) ? '0 : wc_init;
            state_d = S_RUN;
            if ((wc_init == '0) && ((mode == M_DOWN) || (mode == M_UP))) begin
                state_d = S_DONE;
            end
        end else if ((state_q == S_RUN) && wcen) begin
            case (mode)
                M_DOWN: begin
                    wc_d = wc_dec;
                    if (wc_q == ONE) state_d = S_DONE;
                end
                M_UP: begin
                    wc_d = wc_inc;
                    if (wc_inc == wc_init) state_d = S_DONE;
                end
                M_CARRY: begin
                    wc_d = wc_dec;
                    if (wc_q == '0) state_d = S_DONE;
                end
                default: begin
                    wc_d = wc_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
        end
    end

    assign wc   = wc_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

`ifdef WORD_COUNTER_IRQ_EN
    logic irq_q, irq_d;

    // A load that lands in DONE counts as a fresh entry even when already DONE.
    always_comb begin
        irq_d = (state_d == S_DONE) && ((state_q != S_DONE) || wcld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_word_counter.sv
// Self-checking bench for word_counter: directed scenarios plus randomized traffic against a behavioural model.
module tb_word_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] wc_init = '0;
    logic [1:0]   mode = 2'b00;
    logic         wcld = 1'b0;
    logic         wcen = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] wc;
    logic         busy, done, irq;

    int checks = 0;
    int failures = 0;

    word_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .wc_init(wc_init), .mode(mode),
        .wcld(wcld), .wcen(wcen), .clr(clr),
        .wc(wc), .busy(busy), .done(done), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 = IDLE, 1 = RUN, 2 = DONE
    int           m_st = 0;
    int           m_wc = 0;
    bit           m_irq = 1'b0;
    bit           irq_en;

    initial begin
`ifdef WORD_COUNTER_IRQ_EN
        irq_en = 1'b1;
`else
        irq_en = 1'b0;
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        int  nst, nwc;
        bit  entered;
        if (!rst_n) begin
            m_st = 0; m_wc = 0; m_irq = 1'b0;
        end else begin
            nst = m_st; nwc = m_wc; entered = 1'b0;
            if (clr) begin
                nst = 0; nwc = 0;
            end else if (wcld) begin
                nwc = (mode == 2'b01) ? 0 : int'(wc_init);
                nst = 1;
                if (wc_init == 0 && (mode == 2'b00 || mode == 2'b01)) begin
                    nst = 2; entered = 1'b1;
                end
            end else if (m_st == 1 && wcen) begin
                if (mode == 2'b00) begin
                    nwc = (m_wc + 255) % 256;
                    if (m_wc == 1) begin nst = 2; entered = 1'b1; end
                end else if (mode == 2'b01) begin
                    nwc = (m_wc + 1) % 256;
                    if (nwc == int'(wc_init)) begin nst = 2; entered = 1'b1; end
                end else if (mode == 2'b11) begin
                    nwc = (m_wc + 255) % 256;
                    if (m_wc == 0) begin nst = 2; entered = 1'b1; end
                end
            end
            m_st = nst; m_wc = nwc; m_irq = irq_en && entered;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        chk("cyc_wc", int'(wc), m_wc);
        chk("cyc_busy", int'(busy), (m_st == 1) ? 1 : 0);
        chk("cyc_done", int'(done), (m_st == 2) ? 1 : 0);
        chk("cyc_irq", int'(irq), int'(m_irq));
    end

    task automatic tick(input logic l, input logic e, input logic c);
        wcld = l; wcen = e; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic l, e, c;
        #3;
        chk("rst_wc", int'(wc), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_irq", int'(irq), 0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Count-down from 3
        mode = 2'b00; wc_init = 8'd3;
        tick(1, 0, 0); chk("d33_load_wc", int'(wc), 3); chk("d33_load_busy", int'(busy), 1);
        tick(0, 1, 0); chk("d33_wc2", int'(wc), 2);
        tick(0, 1, 0); chk("d33_wc1", int'(wc), 1); chk("d33_notdone", int'(done), 0);
        tick(0, 1, 0); chk("d33_wc0", int'(wc), 0); chk("d33_done", int'(done), 1);
        chk("d33_busy", int'(busy), 0); chk("d33_irq", int'(irq), irq_en ? 1 : 0);
        tick(0, 1, 0); chk("d33_irq_once", int'(irq), 0); chk("d33_hold", int'(wc), 0);

        // Compare-up to 2
        mode = 2'b01; wc_init = 8'd2;
        tick(1, 0, 0); chk("d34_load_wc", int'(wc), 0);
        tick(0, 1, 0); chk("d34_wc1", int'(wc), 1);
        tick(0, 1, 0); chk("d34_wc2", int'(wc), 2); chk("d34_done", int'(done), 1);
        tick(0, 1, 0); chk("d34_hold", int'(wc), 2);

        // Carry-out from zero wraps to all ones
        mode = 2'b11; wc_init = 8'd0;
        tick(1, 0, 0); chk("d35_busy", int'(busy), 1); chk("d35_wc", int'(wc), 0);
        tick(0, 1, 0); chk("d35_wrap", int'(wc), 255); chk("d35_done", int'(done), 1);

        // Clear beats count
        mode = 2'b00; wc_init = 8'd5;
        tick(1, 0, 0); tick(0, 1, 0); tick(0, 1, 0);
        chk("d36_wc3", int'(wc), 3);
        tick(0, 1, 1); chk("d36_wc", int'(wc), 0); chk("d36_done", int'(done), 0);
        chk("d36_busy", int'(busy), 0);

        // Asynchronous reset mid-run
        wc_init = 8'd4;
        tick(1, 0, 0); tick(0, 1, 0); tick(0, 1, 0);
        chk("d37_wc2", int'(wc), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("d37_wc", int'(wc), 0); chk("d37_busy", int'(busy), 0); chk("d37_irq", int'(irq), 0);
        #4 rst_n = 1'b1;

        // Zero load in count-down finishes immediately
        wc_init = 8'd0;
        tick(1, 0, 0); chk("d38_done", int'(done), 1); chk("d38_wc", int'(wc), 0);
        chk("d38_busy", int'(busy), 0); chk("d38_irq", int'(irq), irq_en ? 1 : 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            l = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            if (l) begin
                wc_init = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                      : W'($urandom_range(0, 6));
                mode = 2'($urandom_range(0, 3));
            end else if ($urandom_range(0, 49) == 0) begin
                mode = 2'($urandom_range(0, 3));
            end
            tick(l, e, c);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

        tick(0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_counter.md
WORD_COUNTER -- requirements
Module: word_counter

Interface
REQ-001 Parameter WIDTH, default 8, sets the word-count width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-004 Port wc_init, input, WIDTH bits: initial word count, driven by the upstream load-enabled initial-count register; held stable while counting.
REQ-005 Port mode, input, 2 bits: control-register mode (00 count-down, 01 compare-up, 10 reserved, 11 carry-out).
REQ-006 Port wcld, input, 1 bit: load strobe that starts a transfer.
REQ-007 Port wcen, input, 1 bit: count enable, one word transferred per high cycle.
REQ-008 Port clr, input, 1 bit: synchronous clear.
REQ-009 Port wc, output, WIDTH bits: current word count (registered).
REQ-010 Port busy, output, 1 bit: high while in RUN (registered).
REQ-011 Port done, output, 1 bit: high while in DONE (registered, sticky).
REQ-012 Port irq, output, 1 bit: one-cycle done pulse (see Configuration).

Function
REQ-013 The state machine SHALL have three states, IDLE, RUN and DONE; the encoding is free.
REQ-014 Edge priority SHALL be clr > wcld > wcen.
REQ-015 clr high SHALL force IDLE, wc=0, done=0 and busy=0 at the next edge, from any state.
REQ-016 wcld high, modes 00/10/11: wc<=wc_init and state->RUN; mode 01: wc<=0 and state->RUN; done<=0 in all modes.
REQ-017 wcld with wc_init==0 in mode 00 or 01 SHALL go directly to DONE (done=1 the cycle after the load edge); in mode 11 it SHALL go to RUN.
REQ-018 In RUN, mode 00 with wcen: wc<=wc-1; if wc==1 before the edge, state->DONE on the same edge.
REQ-019 In RUN, mode 01 with wcen: wc<=wc+1; if wc+1==wc_init, state->DONE on the same edge.
REQ-020 In RUN, mode 11 with wcen: wc<=wc-1 modulo 2^WIDTH; if wc==0 before the edge (wrap to all ones), state->DONE on the same edge.
REQ-021 In RUN, mode 10 SHALL ignore wcen, hold wc and remain in RUN.
REQ-022 In RUN with wcen low, wc and state SHALL hold.
REQ-023 In DONE, wc SHALL hold, wcen SHALL be ignored, and the block SHALL leave DONE only on wcld or clr.
REQ-024 In IDLE, wcen SHALL be ignored.
REQ-025 mode SHALL be sampled on every edge; a change during RUN takes effect on the next counting edge with no reload.
REQ-026 wcld during RUN or DONE SHALL restart per REQ-016.
REQ-027 No output SHALL have a combinational path from any input; latency from a load or count edge to the outputs is one edge.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, wc=0, busy=0, done=0 and irq=0, independent of clk.
REQ-029 After rst_n rises, the first rising clk edge SHALL be processed normally.
REQ-030 Reset asserted mid-RUN SHALL abort the transfer with no done or irq pulse.

Configuration
REQ-031 With macro WORD_COUNTER_IRQ_EN defined, irq SHALL be high for exactly one cycle, coincident with the first cycle done is 1 after each RUN->DONE or load->DONE entry.
REQ-032 Without WORD_COUNTER_IRQ_EN, the irq port SHALL remain present and tied to 0; all other behaviour is unchanged.

Verification
REQ-033 Mode 00, wc_init=3, wcld, then 3 wcen cycles -> wc 3,2,1,0; done=1 and busy=0 after the 3rd edge; irq a single pulse (macro on).
REQ-034 Mode 01, wc_init=2, wcld, then 2 wcen cycles -> wc 0,1,2; done after the 2nd edge; a further wcen leaves wc=2.
REQ-035 Mode 11, wc_init=0, WIDTH=8, wcld, then 1 wcen -> wc=8'hFF and done=1.
REQ-036 Mode 00, wc_init=5, wcld, 2 wcen, then clr and wcen in the same cycle -> IDLE, wc=0, done=0.
REQ-037 Mode 00, wc_init=4, 2 wcen, rst_n low mid-cycle -> wc=0 and busy=0 before the next edge, with no irq.
REQ-038 Mode 00, wc_init=0, wcld -> done=1 the next cycle, wc=0, busy never high.
